// File: rtl/uart_rx_monitor.sv
// 8N1 UART receiver sampling with the system clock; keeps a good-byte count.
// Define UART_LINE_BUF_EN to build the newline-terminated line buffer.
module uart_rx_monitor #(
  parameter int CLKS_PER_BIT = 4167,
  parameter int LINE_MAX     = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ser_rx,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  output logic        frame_err,
  output logic [15:0] byte_count,
  output logic        line_valid,
  output logic [7:0]  line_len,
  output logic        line_ovf,
  input  logic [7:0]  line_rd_addr,
  output logic [7:0]  line_rd_data
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

  state_t        state;
  logic          sync1, sync2;
  logic          rx_s;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= ser_rx;
      sync2 <= sync1;
    end
  end

  assign rx_s = sync2;

  // rx_valid / frame_err are single-cycle, mutually exclusive pulses with no
  // back-pressure: a consumer must take rx_data in the cycle rx_valid is high.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      byte_count <= '0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state <= START;
            cnt   <= '0;
          end
        end
        START: begin
          if (cnt == HALF_LAST) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= rx_s ? IDLE : DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == BIT_LAST) begin
            cnt   <= '0;
            shreg <= {rx_s, shreg[7:1]};
            if (bit_idx == 3'd7) state <= STOP;
            else bit_idx <= bit_idx + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt == BIT_LAST) begin
            cnt <= '0;
            if (rx_s) begin
              rx_data    <= shreg;
              rx_valid   <= 1'b1;
              byte_count <= byte_count + 16'd1;
              state      <= IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= BRK;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        BRK: begin
          // Held-low line: one frame_err already reported, wait for idle.
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef UART_LINE_BUF_EN
  localparam int PW = $clog2(LINE_MAX + 1);
  localparam int AW = $clog2(LINE_MAX);
  localparam logic [PW-1:0] PTR_FULL = PW'(LINE_MAX);
  localparam logic [8:0]    LMAX9    = 9'(LINE_MAX);

  logic [7:0]    line_mem [LINE_MAX];
  logic [PW-1:0] wr_ptr;

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr     <= '0;
      line_valid <= 1'b0;
      line_len   <= '0;
      line_ovf   <= 1'b0;
      for (int i = 0; i < LINE_MAX; i++) line_mem[i] <= '0;
    end else begin
      line_valid <= 1'b0;
      if (rx_valid) begin
        if (rx_data == 8'h0D) begin
          line_valid <= 1'b0;
        end else if (rx_data == 8'h0A) begin
          line_valid <= 1'b1;
          line_len   <= 8'(wr_ptr);
          wr_ptr     <= '0;
        end else if (wr_ptr == PTR_FULL) begin
          line_ovf <= 1'b1;
        end else begin
          line_mem[wr_ptr[AW-1:0]] <= rx_data;
          wr_ptr <= wr_ptr + 1'b1;
        end
      end
    end
  end

  assign line_rd_data = ({1'b0, line_rd_addr} < LMAX9) ? line_mem[line_rd_addr[AW-1:0]] : 8'h00;
`else
  localparam int unused_line_max = LINE_MAX;
  logic unused_rd_addr;
  assign unused_rd_addr = ^line_rd_addr;
  assign line_valid   = 1'b0;
  assign line_len     = 8'h00;
  assign line_ovf     = 1'b0;
  assign line_rd_data = 8'h00;
`endif

endmodule

// File: tb/tb_uart_rx_monitor.sv
// Directed bench for uart_rx_monitor at CLKS_PER_BIT=16, LINE_MAX=4.
// Line-buffer checks adapt to whether UART_LINE_BUF_EN is defined.
module tb_uart_rx_monitor;
  localparam int CPB = 16;

  logic        clock = 1'b0;
  logic        reset;
  logic        ser_rx;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        frame_err;
  logic [15:0] byte_count;
  logic        line_valid;
  logic [7:0]  line_len;
  logic        line_ovf;
  logic [7:0]  line_rd_addr;
  logic [7:0]  line_rd_data;

  uart_rx_monitor #(.CLKS_PER_BIT(CPB), .LINE_MAX(4)) dut (
    .clock(clock), .reset(reset), .ser_rx(ser_rx),
    .rx_data(rx_data), .rx_valid(rx_valid), .frame_err(frame_err),
    .byte_count(byte_count), .line_valid(line_valid), .line_len(line_len),
    .line_ovf(line_ovf), .line_rd_addr(line_rd_addr), .line_rd_data(line_rd_data)
  );

  // clock / cycle counter
  always #5 clock = ~clock;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];
  int valid_cnt = 0, ferr_cnt = 0, lv_cnt = 0;
  int valid_cyc = 0, start_cyc = 0;
  logic [7:0] last_len = 8'h00;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // scoreboard: every rx_valid must match the oldest expected byte
  always @(negedge clock) begin
    if (!reset) begin
      if (rx_valid) begin
        valid_cnt++;
        valid_cyc = cyc;
        if (exp_q.size() == 0) check("rx_unexpected", {24'd0, rx_data}, 32'hFFFF_FFFF);
        else check("rx_data_sb", {24'd0, rx_data}, {24'd0, exp_q.pop_front()});
      end
      if (frame_err) ferr_cnt++;
      if (rx_valid || frame_err) check("valid_ferr_excl", {31'd0, rx_valid & frame_err}, 32'd0);
      if (line_valid) begin
        lv_cnt++;
        last_len = line_len;
      end
    end
  end

  // driver tasks (called at a falling edge)
  task automatic send_byte(input logic [7:0] d, input logic stop_bit);
    start_cyc = cyc + 1;
    ser_rx = 1'b0;
    repeat (CPB) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      ser_rx = d[i];
      repeat (CPB) @(negedge clock);
    end
    ser_rx = stop_bit;
    repeat (CPB) @(negedge clock);
  endtask

  task automatic send_good(input logic [7:0] d);
    exp_q.push_back(d);
    send_byte(d, 1'b1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    ser_rx = 1'b1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  int v0, f0, l0, lat;

  initial begin
    reset = 1'b1;
    ser_rx = 1'b1;
    line_rd_addr = 8'h00;
    idle(3);
    check("reset_rx_data", {24'd0, rx_data}, 32'd0);
    check("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("reset_frame_err", {31'd0, frame_err}, 32'd0);
    check("reset_byte_count", {16'd0, byte_count}, 32'd0);
    check("reset_line_valid", {31'd0, line_valid}, 32'd0);
    check("reset_line_len", {24'd0, line_len}, 32'd0);
    check("reset_line_ovf", {31'd0, line_ovf}, 32'd0);
    reset = 1'b0;
    idle(5);

    // single byte 0x41 and latency
    v0 = valid_cnt;
    send_good(8'h41);
    idle(20);
    check("t1_valid_cnt", valid_cnt - v0, 32'd1);
    check("t1_rx_data", {24'd0, rx_data}, 32'h41);
    check("t1_byte_count", {16'd0, byte_count}, 32'd1);
    lat = valid_cyc - start_cyc;
    check("t1_latency_154pm1", {31'd0, lat >= 153 && lat <= 155}, 32'd1);

    // 4-cycle low glitch in idle
    v0 = valid_cnt;
    f0 = ferr_cnt;
    ser_rx = 1'b0;
    idle(4);
    ser_rx = 1'b1;
    idle(40);
    check("t2_no_valid", valid_cnt - v0, 32'd0);
    check("t2_no_ferr", ferr_cnt - f0, 32'd0);
    check("t2_byte_count", {16'd0, byte_count}, 32'd1);

    // framing error then break, then good 0x5A
    do_reset();
    idle(5);
    v0 = valid_cnt;
    f0 = ferr_cnt;
    send_byte(8'h55, 1'b0);
    idle(100);
    ser_rx = 1'b1;
    idle(20);
    check("t3_one_ferr", ferr_cnt - f0, 32'd1);
    check("t3_no_valid_55", valid_cnt - v0, 32'd0);
    check("t3_rx_data_held", {24'd0, rx_data}, 32'd0);
    check("t3_count_after_ferr", {16'd0, byte_count}, 32'd0);
    send_good(8'h5A);
    idle(20);
    check("t3_valid_5a", valid_cnt - v0, 32'd1);
    check("t3_rx_data", {24'd0, rx_data}, 32'h5A);
    check("t3_byte_count", {16'd0, byte_count}, 32'd1);
    check("t3_ferr_total", ferr_cnt - f0, 32'd1);

    // reset in the middle of 0xA5's data bits
    v0 = valid_cnt;
    f0 = ferr_cnt;
    ser_rx = 1'b0;
    idle(CPB);
    for (int i = 0; i < 4; i++) begin
      ser_rx = (8'hA5 >> i) & 8'h01;
      idle(CPB);
    end
    do_reset();
    check("t4_reset_count", {16'd0, byte_count}, 32'd0);
    check("t4_reset_data", {24'd0, rx_data}, 32'd0);
    idle(40);
    check("t4_no_pulse", (valid_cnt - v0) + (ferr_cnt - f0), 32'd0);
    send_good(8'h3C);
    idle(20);
    check("t4_rx_data", {24'd0, rx_data}, 32'h3C);
    check("t4_byte_count", {16'd0, byte_count}, 32'd1);

    // "HI\r\n" back to back
    do_reset();
    idle(5);
    v0 = valid_cnt;
    l0 = lv_cnt;
    send_good(8'h48);
    send_good(8'h49);
    send_good(8'h0D);
    send_good(8'h0A);
    idle(20);
    check("t5_valid_cnt", valid_cnt - v0, 32'd4);
    check("t5_byte_count", {16'd0, byte_count}, 32'd4);
`ifdef UART_LINE_BUF_EN
    check("t5_line_valid_cnt", lv_cnt - l0, 32'd1);
    check("t5_line_len", {24'd0, last_len}, 32'd2);
    line_rd_addr = 8'd0;
    idle(1);
    check("t5_addr0", {24'd0, line_rd_data}, 32'h48);
    line_rd_addr = 8'd1;
    idle(1);
    check("t5_addr1", {24'd0, line_rd_data}, 32'h49);
`else
    check("t5_no_line_valid", lv_cnt - l0, 32'd0);
    check("t5_rd_data_zero", {24'd0, line_rd_data}, 32'd0);
`endif

    // "ABCDEF\n" into a 4-byte buffer
    do_reset();
    idle(5);
    l0 = lv_cnt;
    send_good(8'h41);
    send_good(8'h42);
    send_good(8'h43);
    send_good(8'h44);
    send_good(8'h45);
    send_good(8'h46);
    send_good(8'h0A);
    idle(20);
    check("t6_byte_count", {16'd0, byte_count}, 32'd7);
`ifdef UART_LINE_BUF_EN
    check("t6_line_ovf", {31'd0, line_ovf}, 32'd1);
    check("t6_line_valid_cnt", lv_cnt - l0, 32'd1);
    check("t6_line_len", {24'd0, last_len}, 32'd4);
    for (int i = 0; i < 4; i++) begin
      line_rd_addr = 8'(i);
      idle(1);
      check("t6_buf", {24'd0, line_rd_data}, 32'h41 + i);
    end
    send_good(8'h5A);
    send_good(8'h0A);
    idle(20);
    check("t6_ovf_sticky", {31'd0, line_ovf}, 32'd1);
    check("t6_second_len", {24'd0, last_len}, 32'd1);
    line_rd_addr = 8'd0;
    idle(1);
    check("t6_second_addr0", {24'd0, line_rd_data}, 32'h5A);
`else
    check("t6_no_ovf", {31'd0, line_ovf}, 32'd0);
    check("t6_no_line_valid", lv_cnt - l0, 32'd0);
    check("t6_line_len_zero", {24'd0, line_len}, 32'd0);
`endif

    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
